fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined core. Replaces the single-entry IF stage and IF/ID holding register.
- Issues in-order fetch requests to a variable-latency instruction memory, buffers returned words with their PCs in a DEPTH-entry FIFO, and presents them to decode under a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding in-flight responses.

Parameters:
DATA_W, 16, instruction width
ADDR_W, 16, PC / fetch address width
DEPTH, 4, queue entries (power of two, >=2)
MAX_OUT, 4, max outstanding memory requests (>=1)
RESET_PC, 0, fetch address after reset
PC_STEP, 2, byte increment per instruction

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
redirect  in  1  branch taken / flush; priority over all other events
redirect_pc  in  ADDR_W  new fetch address when redirect=1
halt_fetch  in  1  suppress new requests (hlt seen in decode)
mem_req_valid  out  1  fetch request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  fetch address (= fetch_pc)
mem_rsp_valid  in  1  response word valid; responses return in request order
mem_rsp_data  in  DATA_W  response word
deq_valid  out  1  queue head valid
deq_ready  in  1  decode consumes head (= !stall)
deq_instr  out  DATA_W  head instruction
deq_pc  out  ADDR_W  head instruction address
deq_pc_next  out  ADDR_W  deq_pc + PC_STEP, mod 2^ADDR_W
count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- State: fetch_pc, enq_pc, inflight (issued, not yet responded), drop_cnt (in-flight responses to discard), FIFO rd/wr pointers, count.
- Reset (rst=1 at edge):
  - fetch_pc = enq_pc = RESET_PC; inflight = drop_cnt = count = 0; pointers = 0.
  - mem_req_valid = 0 and deq_valid = 0 while rst is high.
- Issue: mem_req_valid = !rst & !redirect & !halt_fetch & (inflight < MAX_OUT) & (count + inflight - drop_cnt < DEPTH).
  - The credit rule guarantees every accepted response has a free slot; no overflow and no response backpressure.
- Request accept (valid & ready): fetch_pc += PC_STEP (wraps mod 2^ADDR_W); inflight++.
- mem_req_valid may drop without acceptance, e.g. on redirect. The memory must not assume it stays stable.
- Response (mem_rsp_valid):
  - inflight-- always.
  - If drop_cnt > 0: drop_cnt--, word discarded.
  - Otherwise: enqueue {mem_rsp_data, enq_pc}; enq_pc += PC_STEP.
- Accept and response in the same cycle: inflight unchanged.
- Dequeue: when deq_valid & deq_ready & !redirect, advance rd pointer and count--.
- Enqueue and dequeue in the same cycle: count unchanged; legal when full.
- No bypass: an enqueued word is visible at deq_* the cycle after mem_rsp_valid.
  - Minimum latency with memory latency L: request accepted at t, response at t+L, deq_valid at t+L+1.
- deq_valid = (count != 0). deq_instr / deq_pc come from the head entry and are stable while deq_valid & !deq_ready.
- Redirect (cycle with redirect=1):
  - Next state: fetch_pc = enq_pc = redirect_pc; count = 0; pointers reset.
  - drop_cnt = inflight - mem_rsp_valid, so every in-flight response is discarded, including one arriving in the redirect cycle.
  - No request is issued and no dequeue occurs in that cycle.
  - First request to redirect_pc is issued on the following cycle.
- Back-to-back redirects: the second overrides the first; drop_cnt recomputed from the current inflight.
- halt_fetch: no new requests. Outstanding responses still enqueue normally; the queue drains via deq.
- Pointers wrap mod DEPTH. PCs wrap mod 2^ADDR_W.
- rst mid-operation: all state returns to reset values. Responses arriving after reset for pre-reset requests are a memory contract violation; memory is reset by the same rst.

Test Plan:
1. Reset, L=1 memory, mem_req_ready=1, deq_ready=1 -> mem_req_addr 0x0000, 0x0002, 0x0004…; first deq_valid 2 cycles after reset release with deq_pc=0x0000; then one instruction per cycle, deq_pc_next = deq_pc+2.
2. deq_ready=0 from reset, L=3 -> exactly 4 requests (0x0..0x6) accepted, then mem_req_valid=0; count reaches 4 and holds. Raising deq_ready for 1 cycle -> exactly one new request issued.
3. L=3, 2 requests in flight (0x10, 0x12), redirect with redirect_pc=0x0100 -> both responses discarded; queue empty; next request addr 0x0100; first dequeued deq_pc=0x0100.
4. Redirect coincident with mem_rsp_valid and deq_ready=1 with count=2 -> response dropped, no dequeue, count=0 next cycle, drop_cnt = inflight-1.
5. redirect_pc=0xFFFC, continuous fetch -> addresses 0xFFFC, 0xFFFE, 0x0000; deq_pc_next at 0xFFFE is 0x0000.
6. halt_fetch=1 with 3 in flight, then rst asserted mid-stream -> the 3 responses enqueue and requests stop while halt_fetch=1. After rst: count=0, deq_valid=0, mem_req_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue_if.sv
// Bundle of redirect/halt control, instruction-memory request/response and
// decode-side dequeue signals shared by the prefetch queue and its neighbours.
interface fetch_prefetch_queue_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
);
   logic                   redirect;
   logic [ADDR_W-1:0]      redirect_pc;
   logic                   halt_fetch;
   logic                   mem_req_valid;
   logic                   mem_req_ready;
   logic [ADDR_W-1:0]      mem_req_addr;
   logic                   mem_rsp_valid;
   logic [DATA_W-1:0]      mem_rsp_data;
   logic                   deq_valid;
   logic                   deq_ready;
   logic [DATA_W-1:0]      deq_instr;
   logic [ADDR_W-1:0]      deq_pc;
   logic [ADDR_W-1:0]      deq_pc_next;
   logic [$clog2(DEPTH):0] count;

   modport master (
      input  redirect, redirect_pc, halt_fetch, mem_req_ready,
             mem_rsp_valid, mem_rsp_data, deq_ready,
      output mem_req_valid, mem_req_addr, deq_valid, deq_instr,
             deq_pc, deq_pc_next, count
   );

   modport slave (
      output redirect, redirect_pc, halt_fetch, mem_req_ready,
             mem_rsp_valid, mem_rsp_data, deq_ready,
      input  mem_req_valid, mem_req_addr, deq_valid, deq_instr,
             deq_pc, deq_pc_next, count
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues in-order requests to a variable-latency
// memory, buffers returned words with their PCs and hands them to decode.
module fetch_prefetch_queue #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 4,
   parameter int                MAX_OUT  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 2
) (
   input logic                    clk_i,
   input logic                    rst_i,
   fetch_prefetch_queue_if.master bus_io
);
   localparam int                PTR_W     = $clog2(DEPTH);
   localparam int                CNT_W     = PTR_W + 1;
   localparam int                OUT_W     = $clog2(MAX_OUT + 1);
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
   localparam logic [OUT_W-1:0]  MAX_OUT_V = OUT_W'(MAX_OUT);

   logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
   logic [ADDR_W-1:0] enqPc_q, enqPc_d;
   logic [OUT_W-1:0]  inflight_q, inflight_d;
   logic [OUT_W-1:0]  dropCnt_q, dropCnt_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] instrMem_q [DEPTH];
   logic [ADDR_W-1:0] pcMem_q [DEPTH];

   logic [31:0] credit;
   logic        reqValid, reqFire, rspDrop, rspEnq, deqFire;

   // Credits count slots already promised to live in-flight requests, so a
   // response can always be written without backpressuring the memory.
   always_comb begin
      credit   = 32'(count_q) + 32'(inflight_q) - 32'(dropCnt_q);
      reqValid = !rst_i && !bus_io.redirect && !bus_io.halt_fetch &&
                 (inflight_q < MAX_OUT_V) && (credit < 32'(DEPTH));
      reqFire  = reqValid && bus_io.mem_req_ready;
      rspDrop  = bus_io.mem_rsp_valid && (dropCnt_q != '0);
      rspEnq   = bus_io.mem_rsp_valid && (dropCnt_q == '0) && !bus_io.redirect;
      deqFire  = (count_q != '0) && bus_io.deq_ready && !bus_io.redirect;
   end

   always_comb begin
      fetchPc_d  = fetchPc_q;
      enqPc_d    = enqPc_q;
      inflight_d = inflight_q + OUT_W'(reqFire) - OUT_W'(bus_io.mem_rsp_valid);
      dropCnt_d  = dropCnt_q;
      rdPtr_d    = rdPtr_q;
      wrPtr_d    = wrPtr_q;
      count_d    = count_q + CNT_W'(rspEnq) - CNT_W'(deqFire);
      if (reqFire) fetchPc_d = fetchPc_q + STEP;
      if (rspDrop) dropCnt_d = dropCnt_q - OUT_W'(1);
      if (rspEnq) begin
         enqPc_d = enqPc_q + STEP;
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (deqFire) rdPtr_d = rdPtr_q + PTR_W'(1);
      if (bus_io.redirect) begin
         fetchPc_d = bus_io.redirect_pc;
         enqPc_d   = bus_io.redirect_pc;
         dropCnt_d = inflight_q - OUT_W'(bus_io.mem_rsp_valid);
         rdPtr_d   = '0;
         wrPtr_d   = '0;
         count_d   = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetchPc_q  <= RESET_PC;
         enqPc_q    <= RESET_PC;
         inflight_q <= '0;
         dropCnt_q  <= '0;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
      end else begin
         fetchPc_q  <= fetchPc_d;
         enqPc_q    <= enqPc_d;
         inflight_q <= inflight_d;
         dropCnt_q  <= dropCnt_d;
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rspEnq) begin
         instrMem_q[wrPtr_q] <= bus_io.mem_rsp_data;
         pcMem_q[wrPtr_q]    <= enqPc_q;
      end
   end

   assign bus_io.mem_req_valid = reqValid;
   assign bus_io.mem_req_addr  = fetchPc_q;
   assign bus_io.deq_valid     = !rst_i && (count_q != '0);
   assign bus_io.deq_instr     = instrMem_q[rdPtr_q];
   assign bus_io.deq_pc        = pcMem_q[rdPtr_q];
   assign bus_io.deq_pc_next   = pcMem_q[rdPtr_q] + STEP;
   assign bus_io.count         = count_q;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: fixed-latency memory model,
// epoch-tagged scoreboard, vector tables and hand-written corner sequences.
module tb_fetch_prefetch_queue;
   localparam int          DATA_W   = 16;
   localparam int          ADDR_W   = 16;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 4;
   localparam logic [15:0] RESET_PC = 16'h0000;

   typedef struct {
      logic [15:0] addr;
      int          due;
      int          epoch;
   } pend_t;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } sb_t;

   typedef struct {
      logic        deqReady;
      logic        expReqValid;
      logic [15:0] expAddr;
      logic        expDeqValid;
      logic [15:0] expDeqPc;
      int          expCount;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   pend_t pend[$];
   sb_t   sb[$];
   int    cyc     = 0;
   int    epoch   = 0;
   int    latency = 1;
   int    nChecks = 0;
   int    nFails  = 0;
   logic [15:0] expPc = RESET_PC;

   vec_t t1[5];
   vec_t t2[11];

   always #5 clk = ~clk;

   fetch_prefetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

   fetch_prefetch_queue #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT),
      .RESET_PC(RESET_PC), .PC_STEP(2)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus_io(bus)
   );

   function automatic logic [15:0] memWord(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one cycle of inputs at the falling edge, then checks the DUT
   // against the scoreboard once combinational outputs have settled.
   task automatic applyStimulus(input logic dr, input logic hf, input logic rd,
                                input logic [15:0] rpc, input logic mr, input logic rs);
      int          live;
      logic        expV;
      logic [15:0] nxt;
      @(negedge clk);
      rst               = rs;
      bus.deq_ready     = dr;
      bus.halt_fetch    = hf;
      bus.redirect      = rd;
      bus.redirect_pc   = rpc;
      bus.mem_req_ready = mr;
      if (!rs && pend.size() != 0 && pend[0].due <= cyc) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = memWord(pend[0].addr);
      end else begin
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = 16'hDEAD;
      end
      #1;
      if (rs) begin
         checkOutput("rst reqValid", int'(bus.mem_req_valid), 0);
         checkOutput("rst deqValid", int'(bus.deq_valid), 0);
      end else begin
         live = 0;
         foreach (pend[i]) if (pend[i].epoch == epoch) live++;
         expV = !rd && !hf && (pend.size() < MAX_OUT) && ((sb.size() + live) < DEPTH);
         checkOutput("sb reqValid", int'(bus.mem_req_valid), int'(expV));
         if (bus.mem_req_valid) checkOutput("sb reqAddr", int'(bus.mem_req_addr), int'(expPc));
         checkOutput("sb count", int'(bus.count), sb.size());
         checkOutput("sb deqValid", int'(bus.deq_valid), int'(sb.size() != 0));
         if (bus.deq_valid && sb.size() != 0) begin
            nxt = sb[0].pc + 16'd2;
            checkOutput("sb deqInstr", int'(bus.deq_instr), int'(sb[0].instr));
            checkOutput("sb deqPc", int'(bus.deq_pc), int'(sb[0].pc));
            checkOutput("sb deqPcNext", int'(bus.deq_pc_next), int'(nxt));
         end
      end
   endtask

   // Captures the handshakes of the current cycle, crosses the rising edge
   // and advances the memory model and scoreboard accordingly.
   task automatic endCycle();
      logic        fire, deqF, rspNow, rd, rs;
      logic [15:0] rpc;
      int          c;
      pend_t       p;
      fire   = bus.mem_req_valid && bus.mem_req_ready;
      deqF   = bus.deq_valid && bus.deq_ready && !bus.redirect;
      rspNow = bus.mem_rsp_valid;
      rd     = bus.redirect;
      rpc    = bus.redirect_pc;
      rs     = rst;
      c      = cyc;
      @(posedge clk);
      cyc++;
      if (rs) begin
         pend.delete();
         sb.delete();
         expPc = RESET_PC;
         epoch++;
      end else begin
         if (deqF && sb.size() != 0) void'(sb.pop_front());
         if (rspNow && pend.size() != 0) begin
            p = pend.pop_front();
            if (p.epoch == epoch && !rd) sb.push_back('{memWord(p.addr), p.addr});
         end
         if (fire) begin
            pend.push_back('{expPc, c + latency, epoch});
            expPc = expPc + 16'd2;
         end
         if (rd) begin
            sb.delete();
            epoch++;
            expPc = rpc;
         end
      end
   endtask

   task automatic doReset(input int lat);
      latency = lat;
      repeat (2) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
         endCycle();
      end
   endtask

   task automatic runVec(input string tag, input vec_t v);
      applyStimulus(v.deqReady, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput({tag, " reqValid"}, int'(bus.mem_req_valid), int'(v.expReqValid));
      if (v.expReqValid) checkOutput({tag, " reqAddr"}, int'(bus.mem_req_addr), int'(v.expAddr));
      checkOutput({tag, " deqValid"}, int'(bus.deq_valid), int'(v.expDeqValid));
      if (v.expDeqValid) checkOutput({tag, " deqPc"}, int'(bus.deq_pc), int'(v.expDeqPc));
      checkOutput({tag, " count"}, int'(bus.count), v.expCount);
      endCycle();
   endtask

   task automatic step(input logic dr, input logic hf, input logic rd, input logic [15:0] rpc);
      applyStimulus(dr, hf, rd, rpc, 1'b1, 1'b0);
   endtask

   initial begin
      logic        rdR;
      logic [15:0] pcR;
      rst               = 1'b1;
      bus.deq_ready     = 1'b0;
      bus.halt_fetch    = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_pc   = 16'h0;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = 16'h0;

      // Streaming with a one-cycle memory: first word reaches decode two cycles after reset.
      t1[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 0};
      t1[1] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 0};
      t1[2] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0000, 1};
      t1[3] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0002, 1};
      t1[4] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0004, 1};

      // Stalled decode with a three-cycle memory: four requests fill the queue.
      t2[0]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 0};
      t2[1]  = '{1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 0};
      t2[2]  = '{1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 0};
      t2[3]  = '{1'b0, 1'b1, 16'h0006, 1'b0, 16'h0000, 0};
      t2[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1};
      t2[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 2};
      t2[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 3};
      t2[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 4};
      t2[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 4};
      t2[9]  = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h0002, 3};
      t2[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 3};

      doReset(1);
      for (int i = 0; i < 5; i++) runVec("t1", t1[i]);
      doReset(3);
      for (int i = 0; i < 11; i++) runVec("t2", t2[i]);

      // Redirect with two requests in flight: both responses are discarded.
      doReset(3);
      step(1'b1, 1'b0, 1'b1, 16'h0010); endCycle();
      step(1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("t3 addr0", int'(bus.mem_req_addr), 16'h0010); endCycle();
      step(1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("t3 addr1", int'(bus.mem_req_addr), 16'h0012); endCycle();
      step(1'b1, 1'b0, 1'b1, 16'h0100);
      checkOutput("t3 reqValid redirect", int'(bus.mem_req_valid), 0); endCycle();
      step(1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("t3 addr after redirect", int'(bus.mem_req_addr), 16'h0100);
      checkOutput("t3 count after redirect", int'(bus.count), 0); endCycle();
      repeat (3) begin
         step(1'b1, 1'b0, 1'b0, 16'h0);
         checkOutput("t3 deqValid drain", int'(bus.deq_valid), 0); endCycle();
      end
      step(1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("t3 first deqPc", int'(bus.deq_pc), 16'h0100); endCycle();

      // Redirect coinciding with a response and a ready decode stage.
      doReset(1);
      repeat (3) begin step(1'b0, 1'b0, 1'b0, 16'h0); endCycle(); end
      step(1'b1, 1'b0, 1'b1, 16'h0200);
      checkOutput("t4 count before", int'(bus.count), 2); endCycle();
      step(1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput("t4 count after", int'(bus.count), 0);
      checkOutput("t4 deqValid after", int'(bus.deq_valid), 0);
      checkOutput("t4 addr after", int'(bus.mem_req_addr), 16'h0200); endCycle();
      step(1'b0, 1'b0, 1'b0, 16'h0); endCycle();
      step(1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput("t4 kept deqValid", int'(bus.deq_valid), 1);
      checkOutput("t4 kept deqPc", int'(bus.deq_pc), 16'h0200); endCycle();

      // Fetch address and decode PC wrapping at the top of the address space.
      doReset(1);
      step(1'b1, 1'b0, 1'b1, 16'hFFFC); endCycle();
      step(1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("t5 addr FFFC", int'(bus.mem_req_addr), 16'hFFFC); endCycle();
      step(1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("t5 addr FFFE", int'(bus.mem_req_addr), 16'hFFFE); endCycle();
      step(1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("t5 addr wrap", int'(bus.mem_req_addr), 16'h0000);
      checkOutput("t5 deqPc FFFC", int'(bus.deq_pc), 16'hFFFC); endCycle();
      step(1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("t5 deqPc FFFE", int'(bus.deq_pc), 16'hFFFE);
      checkOutput("t5 deqPcNext wrap", int'(bus.deq_pc_next), 16'h0000); endCycle();

      // Halt with three requests in flight, then reset mid-stream.
      doReset(3);
      repeat (3) begin step(1'b0, 1'b0, 1'b0, 16'h0); endCycle(); end
      repeat (3) begin
         step(1'b0, 1'b1, 1'b0, 16'h0);
         checkOutput("t6 halt reqValid", int'(bus.mem_req_valid), 0); endCycle();
      end
      step(1'b0, 1'b1, 1'b0, 16'h0);
      checkOutput("t6 halt count", int'(bus.count), 3);
      checkOutput("t6 halt deqValid", int'(bus.deq_valid), 1); endCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1); endCycle();
      step(1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput("t6 post-rst count", int'(bus.count), 0);
      checkOutput("t6 post-rst deqValid", int'(bus.deq_valid), 0);
      checkOutput("t6 post-rst addr", int'(bus.mem_req_addr), int'(RESET_PC)); endCycle();

      // Random traffic against the scoreboard at two memory latencies.
      for (int l = 2; l <= 5; l += 3) begin
         doReset(l);
         for (int i = 0; i < 400; i++) begin
            rdR = ($urandom_range(0, 19) == 0);
            pcR = 16'($urandom_range(0, 65535)) & 16'hFFFE;
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                          rdR, pcR, 1'($urandom_range(0, 3) != 0), 1'b0);
            endCycle();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
